lcd_frame_ctrl: RTL and testbench

Sequencer that shares the single-digit LCD decoder (4-bit digit in, 8-bit ASCII out, per-digit `sound_alarm` compare) across the four clock digit positions. On each refresh request it steps `digit_sel` through HH:MM, captures the decoded character and writes one full frame to a character LCD: address command first, then four data writes, each with setup/enable/hold timing and busy handshake. It also folds the four per-digit compare results into a single whole-time `alarm_match` flag. It sits between the time/alarm/key registers plus decoder and the LCD pins.

---
 rtl/lcd_frame_ctrl_pkg.sv | 24 ++
 rtl/lcd_frame_ctrl_if.sv | 23 ++
 rtl/lcd_frame_ctrl_write_engine.sv | 74 +++++++
 rtl/lcd_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_lcd_frame_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_frame_ctrl_pkg.sv
// Shared constants for the LCD frame sequencer: LCD command/ASCII codes,
// sequencer state encoding and write-engine phase encoding.
package lcd_pkg;

    localparam logic [7:0] SET_DDRAM   = 8'h80;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ERROR = 8'h3A;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_CHAR = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_EN    = 2'd2;
    localparam logic [1:0] PH_HOLD  = 2'd3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_frame_ctrl_if.sv
// Decoder steering and LCD pin bundle; master is the frame controller side.
interface lcd_frame_ctrl_if;
    logic       refresh;
    logic [7:0] display_char;
    logic       sound_alarm;
    logic       lcd_busy;
    logic [1:0] digit_sel;
    logic       lcd_rs;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic       frame_done;
    logic       alarm_match;

    modport master (
        input  refresh, display_char, sound_alarm, lcd_busy,
        output digit_sel, lcd_rs, lcd_en, lcd_data, frame_done, alarm_match
    );

    modport slave (
        output refresh, display_char, sound_alarm, lcd_busy,
        input  digit_sel, lcd_rs, lcd_en, lcd_data, frame_done, alarm_match
    );
endinterface

// File: rtl/lcd_frame_ctrl_write_engine.sv
// One LCD bus write: SETUP / EN / HOLD timing on a down-counter, busy wait
// in the first setup cycle, start/done pulse handshake with the sequencer.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int EN_CYCLES    = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic lcd_en,
    output logic done
);

    localparam int CNT_W = $clog2(max2(SETUP_CYCLES, EN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYCLES - 1);

    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lcd_en_q, lcd_en_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d = PH_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            PH_SETUP: begin
                // the counter only sits at SETUP_LOAD in the first setup cycle
                if (!(busy && cnt_q == SETUP_LOAD)) begin
                    if (cnt_q == '0) begin
                        phase_d = PH_EN;
                        cnt_d   = EN_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            PH_EN: begin
                if (cnt_q == '0) phase_d = PH_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            PH_HOLD: begin
                done    = 1'b1;
                phase_d = PH_IDLE;
            end
            default: phase_d = PH_IDLE;
        endcase
        lcd_en_d = (phase_d == PH_EN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= '0;
            lcd_en_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            lcd_en_q <= lcd_en_d;
        end
    end

    assign lcd_en = lcd_en_q;

endmodule

// File: rtl/lcd_frame_ctrl.sv
// Frame sequencer: steps digit_sel over HH:MM, writes address command plus
// four characters per refresh, and folds per-digit compares into alarm_match.
module lcd_frame_ctrl
    import lcd_pkg::*;
#(
    parameter int         SETUP_CYCLES = 2,
    parameter int         EN_CYCLES    = 4,
    parameter logic [6:0] DDRAM_ADDR   = 7'h00
) (
    input logic              clock,
    input logic              reset,
    lcd_frame_ctrl_if.master bus
);

    localparam logic [7:0] CMD_BYTE = SET_DDRAM | {1'b0, DDRAM_ADDR};

    logic [2:0] state_q, state_d;
    logic [1:0] digit_sel_q, digit_sel_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic [7:0] lcd_data_q, lcd_data_d;
    logic       pending_q, pending_d;
    logic       match_run_q, match_run_d;
    logic       alarm_match_q, alarm_match_d;
    logic       wr_start, wr_done;

    always_comb begin
        state_d       = state_q;
        digit_sel_d   = digit_sel_q;
        lcd_rs_d      = lcd_rs_q;
        lcd_data_d    = lcd_data_q;
        pending_d     = pending_q;
        match_run_d   = match_run_q;
        alarm_match_d = alarm_match_q;
        wr_start      = 1'b0;

        if (bus.refresh && state_q != ST_IDLE) pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.refresh) begin
                    state_d    = ST_CMD;
                    wr_start   = 1'b1;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = CMD_BYTE;
                end
            end
            ST_CMD: begin
                if (wr_done) begin
                    state_d     = ST_LOAD;
                    digit_sel_d = 2'd0;
                end
            end
            ST_LOAD: begin
                lcd_data_d  = bus.display_char;
                lcd_rs_d    = 1'b1;
                match_run_d = match_run_q & bus.sound_alarm;
                wr_start    = 1'b1;
                state_d     = ST_CHAR;
            end
            ST_CHAR: begin
                if (wr_done) begin
                    if (digit_sel_q != 2'd3) begin
                        digit_sel_d = digit_sel_q + 2'd1;
                        state_d     = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                alarm_match_d = match_run_q;
                match_run_d   = 1'b1;
                digit_sel_d   = 2'd0;
                // a refresh landing in this very cycle still chains the next frame
                if (pending_q || bus.refresh) begin
                    state_d    = ST_CMD;
                    wr_start   = 1'b1;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = CMD_BYTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_CMD && state_q != ST_CMD) pending_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            digit_sel_q   <= 2'd0;
            lcd_rs_q      <= 1'b0;
            lcd_data_q    <= 8'h00;
            pending_q     <= 1'b0;
            match_run_q   <= 1'b1;
            alarm_match_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_sel_q   <= digit_sel_d;
            lcd_rs_q      <= lcd_rs_d;
            lcd_data_q    <= lcd_data_d;
            pending_q     <= pending_d;
            match_run_q   <= match_run_d;
            alarm_match_q <= alarm_match_d;
        end
    end

    lcd_write_engine #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .EN_CYCLES    (EN_CYCLES)
    ) u_write_engine (
        .clock  (clock),
        .reset  (reset),
        .start  (wr_start),
        .busy   (bus.lcd_busy),
        .lcd_en (bus.lcd_en),
        .done   (wr_done)
    );

    assign bus.digit_sel   = digit_sel_q;
    assign bus.lcd_rs      = lcd_rs_q;
    assign bus.lcd_data    = lcd_data_q;
    assign bus.frame_done  = (state_q == ST_DONE);
    assign bus.alarm_match = alarm_match_q;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Directed bench for lcd_frame_ctrl: expected LCD writes are queued when a
// frame is requested and popped by a monitor on each lcd_en rising edge.
module tb_lcd_frame_ctrl;
    import lcd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_frame_ctrl_if bus_if();

    lcd_frame_ctrl #(
        .SETUP_CYCLES (2),
        .EN_CYCLES    (4),
        .DDRAM_ADDR   (7'h00)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int en_rises = 0;
    logic [8:0] sb[$];
    logic [7:0] char_tab[4];
    logic       alarm_tab[4];

    always_comb begin
        bus_if.display_char = char_tab[bus_if.digit_sel];
        bus_if.sound_alarm  = alarm_tab[bus_if.digit_sel];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every lcd_en rise must match the head of the queue.
    initial begin
        logic       en_prev;
        int         en_w;
        logic [8:0] exp_w;
        en_prev = 1'b0;
        en_w    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 1'b0;
                en_w    = 0;
            end else begin
                if (bus_if.lcd_en && !en_prev) begin
                    en_rises++;
                    chk("write_expected", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_w = sb.pop_front();
                        chk("write_rs_data", {bus_if.lcd_rs, bus_if.lcd_data}, exp_w);
                    end
                    en_w = 1;
                end else if (bus_if.lcd_en) begin
                    en_w++;
                end else if (en_prev) begin
                    chk("en_width", en_w, 4);
                end
                en_prev = bus_if.lcd_en;
            end
        end
    end

    task automatic push_frame();
        sb.push_back({1'b0, SET_DDRAM});
        for (int i = 0; i < 4; i++) sb.push_back({1'b1, char_tab[i]});
    endtask

    task automatic pulse_refresh(output int t0);
        bus_if.refresh = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus_if.refresh = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int t0, input int exp_off, input string tag);
        int n = 0;
        while (!bus_if.frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus_if.frame_done ? (cyc - t0) : -1, exp_off);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int r0;
        int fd_cnt;
        char_tab[0] = ASCII_ZERO + 8'd1;
        char_tab[1] = ASCII_ZERO + 8'd2;
        char_tab[2] = ASCII_ZERO + 8'd4;
        char_tab[3] = ASCII_ZERO + 8'd5;
        for (int i = 0; i < 4; i++) alarm_tab[i] = 1'b1;
        bus_if.refresh  = 1'b0;
        bus_if.lcd_busy = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_lcd_en", bus_if.lcd_en, 0);
        chk("rst_lcd_rs", bus_if.lcd_rs, 0);
        chk("rst_lcd_data", bus_if.lcd_data, 8'h00);
        chk("rst_digit_sel", bus_if.digit_sel, 0);
        chk("rst_frame_done", bus_if.frame_done, 0);
        chk("rst_alarm_match", bus_if.alarm_match, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, all digits matching the alarm
        push_frame();
        pulse_refresh(t0);
        chk("cmd_rs", bus_if.lcd_rs, 0);
        chk("cmd_data", bus_if.lcd_data, 8'h80);
        wait_done(t0, 40, "f1_done_cycle");
        chk("f1_alarm_match", bus_if.alarm_match, 1);
        chk("f1_writes", en_rises, 5);
        chk("f1_queue_empty", sb.size(), 0);

        // Busy stall on third character; digit 2 no longer matches
        alarm_tab[2] = 1'b0;
        push_frame();
        pulse_refresh(t0);
        wait_cyc(t0 + 25);
        bus_if.lcd_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("busy_en_low", bus_if.lcd_en, 0);
            chk("busy_data_hold", bus_if.lcd_data, 8'h34);
            @(negedge clk);
        end
        bus_if.lcd_busy = 1'b0;
        wait_done(t0, 50, "busy_done_cycle");
        chk("f2_alarm_match", bus_if.alarm_match, 0);

        // Three refreshes during a frame collapse into one extra frame
        alarm_tab[2] = 1'b1;
        push_frame();
        push_frame();
        pulse_refresh(t0);
        wait_cyc(t0 + 5);
        pulse_refresh(r0);
        wait_cyc(t0 + 20);
        pulse_refresh(r0);
        wait_cyc(t0 + 40);
        chk("pend_done1", bus_if.frame_done, 1);
        pulse_refresh(r0);
        chk("pend_cmd_rs", bus_if.lcd_rs, 0);
        chk("pend_cmd_data", bus_if.lcd_data, 8'h80);
        chk("pend_no_done", bus_if.frame_done, 0);
        wait_done(t0, 80, "pend_done2");
        r0 = en_rises;
        fd_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus_if.frame_done) fd_cnt++;
            @(negedge clk);
        end
        chk("pend_idle_writes", en_rises - r0, 0);
        chk("pend_idle_frames", fd_cnt, 0);
        chk("pend_alarm_match", bus_if.alarm_match, 1);

        // Error code passes through unchanged
        char_tab[1] = ASCII_ERROR;
        push_frame();
        pulse_refresh(t0);
        wait_cyc(t0 + 17);
        chk("err_data", bus_if.lcd_data, 8'h3A);
        chk("err_rs", bus_if.lcd_rs, 1);
        wait_done(t0, 40, "err_done_cycle");

        // Asynchronous reset in the middle of the third character's enable
        push_frame();
        pulse_refresh(t0);
        wait_cyc(t0 + 28);
        chk("rstmid_pre_en", bus_if.lcd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_lcd_en", bus_if.lcd_en, 0);
        chk("rstmid_lcd_rs", bus_if.lcd_rs, 0);
        chk("rstmid_lcd_data", bus_if.lcd_data, 8'h00);
        chk("rstmid_digit_sel", bus_if.digit_sel, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r0 = en_rises;
        fd_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.lcd_en || bus_if.frame_done) fd_cnt++;
        end
        chk("rstmid_quiet_writes", en_rises - r0, 0);
        chk("rstmid_quiet_activity", fd_cnt, 0);
        chk("final_queue_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
